// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_arb_pkg
// Brief   : Shared types and defaults for the two-master SRAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int c_aw_default     = 10;
    localparam int c_dw_default     = 8;
    localparam int c_rd_lat_default = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/sram_arb_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module  : sram_arb_valid_pipe
// Brief   : RD_LAT-deep shift of accepted reads, aligning valid with SRAM data.
// Revision: 1.0 - initial release
// ============================================================================
module sram_arb_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_accept,
    output logic o_valid
);

    logic [RD_LAT-1:0] r_pipe;

    generate
        if (RD_LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= i_accept;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[RD_LAT-2:0], i_accept};
                end
            end
        end
    endgenerate

    assign o_valid = r_pipe[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Brief   : Two-master req/gnt bus-lock arbiter in front of a single-port SRAM.
// Revision: 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW     = c_aw_default,
    parameter int DW     = c_dw_default,
    parameter int RD_LAT = c_rd_lat_default
) (
    input  logic          clk50_dup,
    input  logic          rst_n,
    input  logic          a_req,
    output logic          a_gnt,
    input  logic [15:0]   a_address,
    input  logic [DW-1:0] a_write_data,
    input  logic          a_write,
    input  logic          a_read,
    output logic [DW-1:0] a_read_data,
    output logic          a_read_valid,
    input  logic          b_req,
    output logic          b_gnt,
    input  logic [15:0]   b_address,
    input  logic [DW-1:0] b_write_data,
    input  logic          b_write,
    input  logic          b_read,
    output logic [DW-1:0] b_read_data,
    output logic          b_read_valid,
    output logic [AW-1:0] sram_address,
    input  logic [DW-1:0] sram_read_data,
    output logic [DW-1:0] sram_write_data,
    output logic          sram_write_enable
);

    arb_state_t r_state;
    owner_t     r_last_owner;
    logic       r_a_gnt;
    logic       r_b_gnt;
    logic       w_a_accept;
    logic       w_b_accept;
    logic       w_unused_addr_bits;

    // Owner keeps the bus until it drops req; ties go to whoever did not own last.
    always_ff @(posedge clk50_dup) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_a_gnt      <= 1'b0;
            r_b_gnt      <= 1'b0;
            r_last_owner <= OWNER_B;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (a_req && (!b_req || r_last_owner == OWNER_B)) begin
                        r_state <= ST_OWN_A;
                        r_a_gnt <= 1'b1;
                        r_b_gnt <= 1'b0;
                    end else if (b_req) begin
                        r_state <= ST_OWN_B;
                        r_a_gnt <= 1'b0;
                        r_b_gnt <= 1'b1;
                    end
                end
                ST_OWN_A: begin
                    if (!a_req) begin
                        r_last_owner <= OWNER_A;
                        r_a_gnt      <= 1'b0;
                        r_b_gnt      <= b_req;
                        r_state      <= b_req ? ST_OWN_B : ST_IDLE;
                    end
                end
                ST_OWN_B: begin
                    if (!b_req) begin
                        r_last_owner <= OWNER_B;
                        r_b_gnt      <= 1'b0;
                        r_a_gnt      <= a_req;
                        r_state      <= a_req ? ST_OWN_A : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_a_gnt <= 1'b0;
                    r_b_gnt <= 1'b0;
                end
            endcase
        end
    end

    assign a_gnt      = r_a_gnt;
    assign b_gnt      = r_b_gnt;
    assign w_a_accept = a_req & r_a_gnt;
    assign w_b_accept = b_req & r_b_gnt;

    always_comb begin
        sram_address      = '0;
        sram_write_data   = '0;
        sram_write_enable = 1'b0;
        case (r_state)
            ST_OWN_A: begin
                sram_address      = a_address[AW-1:0];
                sram_write_data   = a_write_data;
                sram_write_enable = a_write & w_a_accept;
            end
            ST_OWN_B: begin
                sram_address      = b_address[AW-1:0];
                sram_write_data   = b_write_data;
                sram_write_enable = b_write & w_b_accept;
            end
            default: ;
        endcase
    end

    sram_arb_valid_pipe #(.RD_LAT(RD_LAT)) u_valid_pipe_a (
        .clk      (clk50_dup),
        .rst_n    (rst_n),
        .i_accept (a_read & w_a_accept),
        .o_valid  (a_read_valid)
    );

    sram_arb_valid_pipe #(.RD_LAT(RD_LAT)) u_valid_pipe_b (
        .clk      (clk50_dup),
        .rst_n    (rst_n),
        .i_accept (b_read & w_b_accept),
        .o_valid  (b_read_valid)
    );

    assign a_read_data = sram_read_data;
    assign b_read_data = sram_read_data;

    // Masters present 16-bit addresses; only the low AW bits reach the SRAM.
    assign w_unused_addr_bits = ^{a_address[15:AW], b_address[15:AW]};

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_arbiter
// Brief   : Self-checking bench: directed vector table, round-robin sequence,
//           and randomized traffic against a behavioural arbiter/SRAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AW     = 10;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;

    logic          clk50_dup = 1'b0;
    logic          rst_n;
    logic          a_req, b_req, a_write, a_read, b_write, b_read;
    logic          a_gnt, b_gnt, a_read_valid, b_read_valid;
    logic [15:0]   a_address, b_address;
    logic [DW-1:0] a_write_data, b_write_data, a_read_data, b_read_data;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_read_data, sram_write_data;
    logic          sram_write_enable;

    always #10 clk50_dup = ~clk50_dup;

    sram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk50_dup         (clk50_dup),
        .rst_n             (rst_n),
        .a_req             (a_req),
        .a_gnt             (a_gnt),
        .a_address         (a_address),
        .a_write_data      (a_write_data),
        .a_write           (a_write),
        .a_read            (a_read),
        .a_read_data       (a_read_data),
        .a_read_valid      (a_read_valid),
        .b_req             (b_req),
        .b_gnt             (b_gnt),
        .b_address         (b_address),
        .b_write_data      (b_write_data),
        .b_write           (b_write),
        .b_read            (b_read),
        .b_read_data       (b_read_data),
        .b_read_valid      (b_read_valid),
        .sram_address      (sram_address),
        .sram_read_data    (sram_read_data),
        .sram_write_data   (sram_write_data),
        .sram_write_enable (sram_write_enable)
    );

    // Synchronous block RAM, read-first, one cycle latency.
    logic [DW-1:0] sram_mem [0:1023];
    always @(posedge clk50_dup) begin
        sram_read_data <= sram_mem[sram_address];
        if (sram_write_enable) sram_mem[sram_address] = sram_write_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B, plus expected memory image.
    int            m_owner, m_last;
    logic          m_va, m_vb;
    logic [DW-1:0] m_vd_a, m_vd_b;
    logic [DW-1:0] m_mem [0:1023];

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_va    = 1'b0;
        m_vb    = 1'b0;
    endtask

    task automatic model_edge();
        bit            acc_a, acc_b;
        int            ia, ib;
        logic [DW-1:0] da, db;
        acc_a = (m_owner == 1) && a_req;
        acc_b = (m_owner == 2) && b_req;
        ia = int'(a_address) % 1024;
        ib = int'(b_address) % 1024;
        da = m_mem[ia];
        db = m_mem[ib];
        if (acc_a && a_write) m_mem[ia] = a_write_data;
        if (acc_b && b_write) m_mem[ib] = b_write_data;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_va = acc_a && a_read;  m_vd_a = da;
            m_vb = acc_b && b_read;  m_vd_b = db;
            if (m_owner == 0) begin
                if (a_req && b_req) m_owner = (m_last == 1) ? 2 : 1;
                else if (a_req)     m_owner = 1;
                else if (b_req)     m_owner = 2;
            end else if (m_owner == 1 && !a_req) begin
                m_last  = 1;
                m_owner = b_req ? 2 : 0;
            end else if (m_owner == 2 && !b_req) begin
                m_last  = 2;
                m_owner = a_req ? 1 : 0;
            end
        end
    endtask

    // Called shortly after a falling edge with inputs already applied.
    task automatic cycle();
        bit            e_we;
        logic [AW-1:0] e_addr;
        #1;
        e_we   = ((m_owner == 1) && a_req && a_write) || ((m_owner == 2) && b_req && b_write);
        e_addr = (m_owner == 1) ? a_address[AW-1:0] : (m_owner == 2) ? b_address[AW-1:0] : '0;
        chk("m_a_gnt", 32'(a_gnt), 32'(m_owner == 1));
        chk("m_b_gnt", 32'(b_gnt), 32'(m_owner == 2));
        chk("m_we", 32'(sram_write_enable), 32'(e_we));
        chk("m_addr", 32'(sram_address), 32'(e_addr));
        if (e_we) chk("m_wdata", 32'(sram_write_data), (m_owner == 1) ? 32'(a_write_data) : 32'(b_write_data));
        chk("m_a_valid", 32'(a_read_valid), 32'(m_va));
        chk("m_b_valid", 32'(b_read_valid), 32'(m_vb));
        if (m_va) chk("m_a_rdata", 32'(a_read_data), 32'(m_vd_a));
        if (m_vb) chk("m_b_rdata", 32'(b_read_data), 32'(m_vd_b));
        @(posedge clk50_dup);
        #1;
        model_edge();
        @(negedge clk50_dup);
    endtask

    // ctl = {rst_n, a_req, b_req, a_write, a_read, b_write, b_read}
    // ex  = {a_gnt, b_gnt, sram_write_enable, a_read_valid}
    typedef struct {
        logic [6:0]  ctl;
        logic [15:0] a_addr;
        logic [15:0] b_addr;
        logic [7:0]  a_wd;
        logic [7:0]  b_wd;
        logic [3:0]  ex;
        logic [9:0]  e_addr;
        logic [7:0]  e_rd;
    } row_t;

    row_t rows [16];

    initial begin
        int own, prev;
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = '0;
            m_mem[i]    = '0;
        end
        rows[0]  = '{7'b0110000, 16'hF123, 16'h0000, 8'h00, 8'h00, 4'b0000, 10'h000, 8'h00};
        rows[1]  = '{7'b0110000, 16'hF123, 16'h0000, 8'h00, 8'h00, 4'b0000, 10'h000, 8'h00};
        rows[2]  = '{7'b0110000, 16'hF123, 16'h0000, 8'h00, 8'h00, 4'b0000, 10'h000, 8'h00};
        rows[3]  = '{7'b1110000, 16'hF123, 16'h0000, 8'h00, 8'h00, 4'b0000, 10'h000, 8'h00};
        rows[4]  = '{7'b1111000, 16'hF123, 16'h0000, 8'h5A, 8'h00, 4'b1010, 10'h123, 8'h00};
        rows[5]  = '{7'b1110100, 16'hF123, 16'h0000, 8'h00, 8'h00, 4'b1000, 10'h123, 8'h00};
        rows[6]  = '{7'b1110010, 16'hF123, 16'h0044, 8'h00, 8'h33, 4'b1001, 10'h123, 8'h5A};
        rows[7]  = '{7'b1010010, 16'hF123, 16'h0044, 8'h00, 8'h33, 4'b1000, 10'h123, 8'h00};
        rows[8]  = '{7'b1010010, 16'hF123, 16'h0044, 8'h00, 8'h33, 4'b0110, 10'h044, 8'h00};
        rows[9]  = '{7'b1000000, 16'hF123, 16'h0044, 8'h00, 8'h00, 4'b0100, 10'h044, 8'h00};
        rows[10] = '{7'b1000000, 16'h0000, 16'h0000, 8'h00, 8'h00, 4'b0000, 10'h000, 8'h00};
        rows[11] = '{7'b1100100, 16'h0044, 16'h0000, 8'h00, 8'h00, 4'b0000, 10'h000, 8'h00};
        rows[12] = '{7'b1100100, 16'h0044, 16'h0000, 8'h00, 8'h00, 4'b1000, 10'h044, 8'h00};
        rows[13] = '{7'b1100100, 16'h0123, 16'h0000, 8'h00, 8'h00, 4'b1001, 10'h123, 8'h33};
        rows[14] = '{7'b0100100, 16'h0123, 16'h0000, 8'h00, 8'h00, 4'b1001, 10'h123, 8'h5A};
        rows[15] = '{7'b1000000, 16'h0000, 16'h0000, 8'h00, 8'h00, 4'b0000, 10'h000, 8'h00};

        rst_n = 1'b0;
        {a_req, b_req, a_write, a_read, b_write, b_read} = '0;
        a_address = '0; b_address = '0; a_write_data = '0; b_write_data = '0;
        repeat (2) @(posedge clk50_dup);
        @(negedge clk50_dup);
        model_reset();

        // Directed vectors: reset, solo access, handover, ungranted strobe, mid-burst reset
        for (int i = 0; i < 16; i++) begin
            {rst_n, a_req, b_req, a_write, a_read, b_write, b_read} = rows[i].ctl;
            a_address    = rows[i].a_addr;
            b_address    = rows[i].b_addr;
            a_write_data = rows[i].a_wd;
            b_write_data = rows[i].b_wd;
            #1;
            chk($sformatf("row%0d_a_gnt", i), 32'(a_gnt), 32'(rows[i].ex[3]));
            chk($sformatf("row%0d_b_gnt", i), 32'(b_gnt), 32'(rows[i].ex[2]));
            chk($sformatf("row%0d_we", i), 32'(sram_write_enable), 32'(rows[i].ex[1]));
            chk($sformatf("row%0d_a_valid", i), 32'(a_read_valid), 32'(rows[i].ex[0]));
            chk($sformatf("row%0d_addr", i), 32'(sram_address), 32'(rows[i].e_addr));
            if (rows[i].ex[0]) chk($sformatf("row%0d_rdata", i), 32'(a_read_data), 32'(rows[i].e_rd));
            cycle();
        end

        // Round robin: the owner drops req for one cycle while the other keeps asking
        {a_write, a_read, b_write, b_read} = '0;
        a_req = 1'b0; b_req = 1'b0;
        cycle();
        a_req = 1'b1; b_req = 1'b1;
        cycle();
        prev = 2;
        for (int i = 0; i < 8; i++) begin
            a_req = 1'b1; b_req = 1'b1;
            #1;
            own = (a_gnt === 1'b1 && b_gnt === 1'b0) ? 1 : (b_gnt === 1'b1 && a_gnt === 1'b0) ? 2 : 0;
            chk($sformatf("rr%0d_owner", i), 32'(own), (prev == 1) ? 32'd2 : 32'd1);
            prev = own;
            if (own == 1) a_req = 1'b0;
            else          b_req = 1'b0;
            cycle();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            a_req        = ($urandom_range(0, 3) != 0) ? a_req : ~a_req;
            b_req        = ($urandom_range(0, 3) != 0) ? b_req : ~b_req;
            a_write      = $urandom_range(0, 1) == 1;
            a_read       = $urandom_range(0, 1) == 1;
            b_write      = $urandom_range(0, 1) == 1;
            b_read       = $urandom_range(0, 1) == 1;
            a_address    = 16'($urandom()) & 16'hFC0F;
            b_address    = 16'($urandom()) & 16'hFC0F;
            a_write_data = 8'($urandom());
            b_write_data = 8'($urandom());
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
